// File: rtl/dac_slew_sequencer.sv
// dac_slew_sequencer: slews a DAC code toward a target in bounded steps, spacing write strobes by at least MIN_GAP cycles.
module dac_slew_sequencer #(
  parameter int MIN_GAP = 8,
  parameter int CODE_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              tgt_valid,
  input  logic [CODE_W-1:0] step_size,
  input  logic [15:0]       update_div,
  input  logic              force_en,
  output logic [CODE_W-1:0] dac_out,
  output logic              dac_out_en,
  output logic              busy,
  output logic              at_target
);
  localparam int GW = $clog2(MIN_GAP + 1);
  typedef enum logic [1:0] {IDLE, SLEW, FORCE} state_t;
  state_t            st_q, st_d;
  logic [CODE_W-1:0] cur_q, cur_d, tgt_q, tgt_d, step_q, step_d, out_q, out_d;
  logic [15:0]       div_q, div_d, cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              en_q, en_d;
  logic              gap_ok, tick, up;
  logic [CODE_W:0]   diff;
  logic [CODE_W-1:0] stepped;
  assign gap_ok  = gap_q >= GW'(MIN_GAP - 1);
  assign tick    = cnt_q >= div_q - 16'd1;
  assign up      = tgt_q > cur_q;
  assign diff    = up ? {1'b0, tgt_q} - {1'b0, cur_q} : {1'b0, cur_q} - {1'b0, tgt_q};
  // No overshoot: when the remaining distance exceeds the step, cur+/-step stays inside the code range.
  assign stepped = diff <= {1'b0, step_q} ? tgt_q : up ? cur_q + step_q : cur_q - step_q;
  always_comb begin
    st_d   = st_q;
    cur_d  = cur_q;
    tgt_d  = tgt_q;
    step_d = step_q;
    div_d  = div_q;
    out_d  = out_q;
    en_d   = 1'b0;
    cnt_d  = &cnt_q ? cnt_q : cnt_q + 16'd1;
    if (st_q == SLEW && tick && gap_ok) begin
      cur_d = stepped;
      out_d = stepped;
      en_d  = 1'b1;
      cnt_d = '0;
      st_d  = stepped == tgt_q ? IDLE : SLEW;
    end else if (st_q == FORCE && gap_ok) begin
      cur_d = tgt_q;
      out_d = tgt_q;
      en_d  = 1'b1;
      st_d  = IDLE;
    end
    // A new request is applied after any coincident tick, so that tick still uses the old target.
    if (tgt_valid) begin
      tgt_d  = tgt_code;
      step_d = step_size == '0 ? CODE_W'(1) : step_size;
      div_d  = update_div < 16'(MIN_GAP) ? 16'(MIN_GAP) : update_div;
      if (tgt_code == cur_d) st_d = IDLE;
      else if (force_en && gap_ok && !en_d) begin
        cur_d = tgt_code;
        out_d = tgt_code;
        en_d  = 1'b1;
        st_d  = IDLE;
      end else if (force_en) st_d = FORCE;
      else begin
        st_d  = SLEW;
        cnt_d = st_q == SLEW ? cnt_d : 16'd1;
      end
    end
    gap_d = en_d ? '0 : gap_q >= GW'(MIN_GAP) ? gap_q : gap_q + GW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cur_q  <= '0;
      tgt_q  <= '0;
      step_q <= CODE_W'(1);
      div_q  <= 16'(MIN_GAP);
      cnt_q  <= '0;
      out_q  <= '0;
      en_q   <= 1'b0;
      gap_q  <= GW'(MIN_GAP);
    end else begin
      st_q   <= st_d;
      cur_q  <= cur_d;
      tgt_q  <= tgt_d;
      step_q <= step_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      en_q   <= en_d;
      gap_q  <= gap_d;
    end
  end
  assign dac_out    = out_q;
  assign dac_out_en = en_q;
  assign busy       = st_q != IDLE;
  assign at_target  = st_q == IDLE && cur_q == tgt_q;
endmodule

// File: tb/tb_dac_slew_sequencer.sv
// tb_dac_slew_sequencer: directed scenarios plus random requests against a time-based reference model.
module tb_dac_slew_sequencer;
  localparam int MIN_GAP = 8;
  logic        clk = 1'b0, rst = 1'b0, tgt_valid = 1'b0, force_en = 1'b0;
  logic [11:0] tgt_code = '0, step_size = '0;
  logic [15:0] update_div = '0;
  logic [11:0] dac_out;
  logic        dac_out_en, busy, at_target;
  int n_chk = 0, n_bad = 0, now = 0;
  int m_cur, m_tgt, m_step, m_div, m_mode, m_base, m_last, m_out;
  bit m_en;
  int p_cyc[$], p_code[$];
  int e_off[5], e_code[5];
  int n0, pt;
  dac_slew_sequencer #(.MIN_GAP(MIN_GAP), .CODE_W(12)) dut (
    .clk(clk), .rst(rst), .tgt_code(tgt_code), .tgt_valid(tgt_valid),
    .step_size(step_size), .update_div(update_div), .force_en(force_en),
    .dac_out(dac_out), .dac_out_en(dac_out_en), .busy(busy), .at_target(at_target)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, now, got, exp);
    end
  endtask
  // Model works in absolute cycle numbers: a slew pulse is due at base+div, and any pulse needs MIN_GAP since the last.
  task automatic model(input bit r, input bit v, input int c, input int s, input int d, input bit f);
    bit ok, was_slew;
    int diff;
    m_en = 0;
    if (r) begin
      m_cur = 0; m_tgt = 0; m_mode = 0; m_out = 0; m_last = -1000;
      m_step = 1; m_div = MIN_GAP; m_base = 0;
    end else begin
      ok = now + 1 - m_last >= MIN_GAP;
      was_slew = m_mode == 1;
      if (m_mode == 1 && now + 1 >= m_base + m_div && ok) begin
        diff = m_tgt - m_cur;
        if (diff <= m_step && -diff <= m_step) m_cur = m_tgt;
        else m_cur += diff > 0 ? m_step : -m_step;
        m_out = m_cur; m_en = 1; m_last = now + 1; m_base = now + 1;
        if (m_cur == m_tgt) m_mode = 0;
      end else if (m_mode == 2 && ok) begin
        m_cur = m_tgt; m_out = m_cur; m_en = 1; m_last = now + 1; m_mode = 0;
      end
      if (v) begin
        m_tgt = c; m_step = s == 0 ? 1 : s; m_div = d < MIN_GAP ? MIN_GAP : d;
        if (c == m_cur) m_mode = 0;
        else if (f && ok && !m_en) begin
          m_cur = c; m_out = c; m_en = 1; m_last = now + 1; m_mode = 0;
        end else if (f) m_mode = 2;
        else begin
          if (!was_slew) m_base = now;
          m_mode = 1;
        end
      end
    end
    now++;
  endtask
  task automatic cyc(input bit r, input bit v, input int c, input int s, input int d, input bit f);
    rst = r; tgt_valid = v; tgt_code = 12'(c); step_size = 12'(s); update_div = 16'(d); force_en = f;
    @(posedge clk);
    model(r, v, c, s, d, f);
    #1;
    check("en", int'(dac_out_en), int'(m_en));
    check("out", int'(dac_out), m_out);
    check("busy", int'(busy), int'(m_mode != 0));
    check("at_target", int'(at_target), int'(m_mode == 0 && m_cur == m_tgt));
    if (dac_out_en) begin
      p_cyc.push_back(now);
      p_code.push_back(int'(dac_out));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic req(input int c, input int s, input int d, input bit f);
    cyc(0, 1, c, s, d, f);
  endtask
  task automatic chk_log(input string tag, input int n, input int base);
    check({tag, "_count"}, p_cyc.size(), n);
    for (int i = 0; i < n && i < p_cyc.size(); i++) begin
      check({tag, "_time"}, p_cyc[i] - base, e_off[i]);
      check({tag, "_code"}, p_code[i], e_code[i]);
    end
    p_cyc.delete();
    p_code.delete();
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_out", int'(dac_out), 0);
    check("rst_en", int'(dac_out_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_at", int'(at_target), 1);
    p_cyc.delete(); p_code.delete();
    n0 = now; req(250, 100, 10, 0); idle(35);
    e_off = '{10, 20, 30, 0, 0}; e_code = '{100, 200, 250, 0, 0};
    chk_log("up", 3, n0);
    check("up_at", int'(at_target), 1);
    check("up_busy", int'(busy), 0);
    n0 = now; req(0, 300, 10, 0); idle(20);
    e_off = '{10, 0, 0, 0, 0}; e_code = '{0, 0, 0, 0, 0};
    chk_log("down", 1, n0);
    n0 = now; req(3, 0, 2, 0); idle(30);
    e_off = '{8, 16, 24, 0, 0}; e_code = '{1, 2, 3, 0, 0};
    chk_log("clamp", 3, n0);
    req(500, 100, 10, 0);
    for (int i = 0; i < 20 && !dac_out_en; i++) idle(1);
    check("force_first_pulse", int'(dac_out_en), 1);
    pt = now;
    p_cyc.delete(); p_code.delete();
    idle(1); req(4095, 1, 10, 1); idle(14);
    e_off = '{8, 0, 0, 0, 0}; e_code = '{4095, 0, 0, 0, 0};
    chk_log("force", 1, pt);
    cyc(1, 0, 0, 0, 0, 0);
    p_cyc.delete(); p_code.delete();
    n0 = now; req(1000, 100, 10, 0);
    while (now < n0 + 33) idle(1);
    req(150, 100, 10, 0); idle(25);
    e_off = '{10, 20, 30, 40, 50}; e_code = '{100, 200, 300, 200, 150};
    chk_log("retarget", 5, n0);
    check("retarget_at", int'(at_target), 1);
    n0 = now; req(500, 100, 10, 0);
    while (now < n0 + 9) idle(1);
    cyc(1, 0, 0, 0, 0, 0); idle(15);
    check("rstmid_out", int'(dac_out), 0);
    check("rstmid_at", int'(at_target), 1);
    req(0, 5, 10, 0); idle(10);
    check("same_busy", int'(busy), 0);
    chk_log("rstmid", 0, n0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) cyc(1, 0, 0, 0, 0, 0);
      else if ($urandom_range(0, 24) == 0)
        cyc(0, 1, $urandom_range(0, 4) == 0 ? m_cur : int'($urandom_range(0, 4095)),
            $urandom_range(0, 5) == 0 ? 0 : int'($urandom_range(1, $urandom_range(0, 3) == 0 ? 4095 : 700)),
            int'($urandom_range(0, 20)), $urandom_range(0, 3) == 0);
      else idle(1);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/dac_slew_sequencer.md
Name: dac_slew_sequencer

Overview:
- Upstream feeder for the AD5445 parallel-DAC write stage.
- Accepts a target DAC code from control logic and slews the current code toward it in programmable steps at a programmable update rate.
- Each update is a one-cycle dac_out/dac_out_en strobe to the DAC write stage.
- Enforces a minimum gap between strobes so the downstream write cycle (CS/RW pulse plus recovery) always completes before the next request.

Parameters:
MIN_GAP, 8, minimum clk cycles between consecutive dac_out_en pulses (must be >= 5; downstream write takes 5 cycles)
CODE_W, 12, DAC code width

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset; one clock, synchronous, active-high
tgt_code  input  CODE_W  requested target code, 0..4095
tgt_valid  input  1  one-cycle strobe; latches tgt_code, step_size, update_div, force_en
step_size  input  CODE_W  max code change per update; 0 treated as 1
update_div  input  16  cycles between slew updates; effective value eff_div = max(update_div, MIN_GAP)
force_en  input  1  sampled with tgt_valid; 1 = jump directly to target in a single write
dac_out  output  CODE_W  code presented to DAC write stage
dac_out_en  output  1  one-cycle write request
busy  output  1  high while not IDLE
at_target  output  1  high when IDLE and cur_code == target

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - dac_out=0, dac_out_en=0, busy=0, at_target=1.
  - Internal cur_code=0, target=0, div_cnt=0.
  - gap_cnt=MIN_GAP, so the first write is not blocked.
- Reset mid-slew aborts immediately; no pulse is issued in the reset cycle or after it.
- Registers latched on tgt_valid: target, step (0 -> 1), eff_div, force.
- gap_cnt:
  - Cleared to 0 on every dac_out_en pulse.
  - Otherwise increments, saturating at MIN_GAP.
  - A pulse may only issue when gap_cnt >= MIN_GAP-1, i.e. pulses are >= MIN_GAP cycles apart.
- States: IDLE, SLEW, FORCE.
- IDLE:
  - On tgt_valid with tgt_code == cur_code: stay in IDLE, no pulse.
  - On tgt_valid with force_en=1: go to FORCE.
  - Otherwise on tgt_valid: go to SLEW with div_cnt=0.
- SLEW:
  - div_cnt increments each cycle.
  - A tick occurs when div_cnt == eff_div-1; div_cnt then returns to 0.
  - On tick, with gap satisfied: cur_code moves toward target by step.
    - If |target - cur_code| <= step, cur_code = target (no overshoot, no wrap).
    - Arithmetic is done at CODE_W+1 bits, so results never wrap below 0 or above 4095.
    - dac_out <= new cur_code and dac_out_en=1 for one cycle.
  - If the gap is not satisfied at a tick, the tick is held pending until it is; div_cnt restarts only after the pulse.
  - When cur_code reaches target, return to IDLE after the pulse.
- Latency: with tgt_valid in cycle N, the first pulse is in cycle N+eff_div.
- FORCE:
  - Issues a single pulse with dac_out=target, cur_code=target, as soon as the gap is satisfied.
  - Minimum latency is 1 cycle after tgt_valid. Then returns to IDLE.
- tgt_valid while busy:
  - New target, step and eff_div are latched.
  - In SLEW, div_cnt continues (cadence is preserved); new parameters apply from the next tick.
  - force_en=1 goes to FORCE.
  - If the new target equals cur_code, go to IDLE without a pulse.
  - tgt_valid coinciding with a tick: the tick uses the old target; the new values take effect afterwards.
- dac_out holds its last value between pulses.
- at_target is combinational from registered state; it is 0 during FORCE/SLEW.

Test Plan:
- Upward slew: reset; tgt_valid with target=250, step=100, div=10 at cycle 0 -> pulses at cycles 10, 20, 30 with codes 100, 200, 250; then at_target=1, busy=0.
- Downward slew with large step: from cur=250, target=0, step=300, div=10 -> exactly one pulse, code 0, no wrap to 4095.
- Clamping: from 0, target=3, step=0, div=2 (so eff_div=8) -> pulses at cycles 8, 16, 24 with codes 1, 2, 3.
- Force with gap guard: force target=4095 two cycles after a slew pulse -> pulse delayed to exactly MIN_GAP cycles after the previous pulse, code 4095, one pulse only.
- Retarget mid-slew: 0→1000 with step=100, div=10; after the pulse at code 300, retarget to 150 -> next pulses are 200, then 150, on the unchanged 10-cycle cadence; then IDLE.
- Reset mid-slew and same-target request: assert rst one cycle before an expected tick -> no pulse, dac_out=0, at_target=1; then tgt_valid with target=0 -> no pulse, stays IDLE.
